// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the multicycle control unit and the multiply/divide unit.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Bit-serial multiply/divide unit with HI/LO registers: shift-add multiplier and
// restoring divider over signed magnitudes, with sign fix-up in a final cycle.
//
// state | meaning
// IDLE  | waiting for start; hi_we/lo_we honoured here
// RUN   | WIDTH iterations of shift-add or restoring divide
// FIX   | sign correction, hi/lo write (or div_zero flag), done pulse
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset,
  mult_div_unit_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic               neg_lo, neg_hi, dz_q;
  logic               busy_q, done_q, div_zero_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               signed_op, a_neg, b_neg, b_zero;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   mul_add;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign signed_op = ~bus.op[0];
  assign a_neg     = signed_op & bus.a[WIDTH-1];
  assign b_neg     = signed_op & bus.b[WIDTH-1];
  assign a_mag     = a_neg ? -bus.a : bus.a;
  assign b_mag     = b_neg ? -bus.b : bus.b;
  assign b_zero    = (bus.b == '0);

  // Multiply: acc = {partial high, remaining multiplier}; carry rides into the shift.
  assign mul_add  = acc[0] ? opnd : '0;
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient}; remainder stays below divisor.
  assign div_shift = acc[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, opnd};
  assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

  assign prod_fix = neg_lo ? -acc : acc;
  assign quo_fix  = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.start) state_nx = (bus.op[1] && b_zero) ? FIX : RUN;
      RUN:  if (cnt == LAST) state_nx = FIX;
      FIX:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      op_q       <= 2'b00;
      opnd       <= '0;
      acc        <= '0;
      neg_lo     <= 1'b0;
      neg_hi     <= 1'b0;
      dz_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q       <= bus.op;
            opnd       <= bus.op[1] ? b_mag : a_mag;
            acc        <= {{WIDTH{1'b0}}, (bus.op[1] ? a_mag : b_mag)};
            neg_lo     <= a_neg ^ b_neg;
            neg_hi     <= a_neg;
            dz_q       <= bus.op[1] & b_zero;
            div_zero_q <= 1'b0;
            busy_q     <= 1'b1;
            cnt        <= '0;
          end else begin
            if (bus.hi_we) hi_q <= bus.a;
            if (bus.lo_we) lo_q <= bus.a;
          end
        end
        RUN: begin
          acc <= op_q[1] ? div_next : mul_next;
          cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
        FIX: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          if (dz_q) begin
            div_zero_q <= 1'b1;
          end else if (op_q[1]) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
        end
        default: busy_q <= 1'b0;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit at WIDTH = 32: latency, results, signs, div-by-zero,
// HI/LO writes, ignored requests while busy and mid-operation reset.
module tb_mult_div_unit;
  localparam int W     = 32;
  localparam int LIMIT = 100;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  mult_div_unit_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Drives start at the current negedge, then waits for done (bounded).
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        output int lat, output int busy_cycles, output bit overlap,
                        output bit moved);
    logic [W-1:0] h0, l0;
    h0 = bus.hi;
    l0 = bus.lo;
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = av;
    bus.b     = bv;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 32'hDEAD_BEEF;
    bus.b     = 32'h0BAD_F00D;
    lat = 1;
    busy_cycles = 0;
    overlap = 1'b0;
    moved = 1'b0;
    while (!bus.done && lat < LIMIT) begin
      if (bus.busy) busy_cycles++;
      if (bus.hi !== h0 || bus.lo !== l0) moved = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (bus.done && bus.busy) overlap = 1'b1;
  endtask

  task automatic test_reset();
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    tests++; if (bus.div_zero !== 1'b0) begin fails++; $display("FAIL reset_dz: got %b expected 0", bus.div_zero); end
    tests++; if (bus.hi !== 32'h0) begin fails++; $display("FAIL reset_hi: got %h expected 0", bus.hi); end
    tests++; if (bus.lo !== 32'h0) begin fails++; $display("FAIL reset_lo: got %h expected 0", bus.lo); end
  endtask

  task automatic test_multu();
    int lat, bc; bit ov, mv;
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc, ov, mv);
    tests++; if (lat !== 34) begin fails++; $display("FAIL multu_latency: got %0d expected 34", lat); end
    tests++; if (bc !== 33) begin fails++; $display("FAIL multu_busy_cycles: got %0d expected 33", bc); end
    tests++; if (ov !== 1'b0) begin fails++; $display("FAIL multu_done_busy_overlap: got %b expected 0", ov); end
    tests++; if (mv !== 1'b0) begin fails++; $display("FAIL multu_hilo_hold: got %b expected 0", mv); end
    tests++; if (bus.hi !== 32'hFFFF_FFFE) begin fails++; $display("FAIL multu_hi: got %h expected fffffffe", bus.hi); end
    tests++; if (bus.lo !== 32'h0000_0001) begin fails++; $display("FAIL multu_lo: got %h expected 00000001", bus.lo); end
    @(negedge clk);
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL multu_done_pulse: got %b expected 0", bus.done); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL multu_idle_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_mult();
    int lat, bc; bit ov, mv;
    run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, lat, bc, ov, mv);
    tests++; if (lat !== 34) begin fails++; $display("FAIL mult_latency: got %0d expected 34", lat); end
    tests++; if (bus.hi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL mult_neg_hi: got %h expected ffffffff", bus.hi); end
    tests++; if (bus.lo !== 32'hFFFF_FFEB) begin fails++; $display("FAIL mult_neg_lo: got %h expected ffffffeb", bus.lo); end
    @(negedge clk);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, lat, bc, ov, mv);
    tests++; if (bus.hi !== 32'h4000_0000) begin fails++; $display("FAIL mult_min_hi: got %h expected 40000000", bus.hi); end
    tests++; if (bus.lo !== 32'h0) begin fails++; $display("FAIL mult_min_lo: got %h expected 0", bus.lo); end
    @(negedge clk);
  endtask

  task automatic test_div();
    int lat, bc; bit ov, mv;
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, lat, bc, ov, mv);
    tests++; if (lat !== 34) begin fails++; $display("FAIL div_latency: got %0d expected 34", lat); end
    tests++; if (bus.lo !== 32'hFFFF_FFFD) begin fails++; $display("FAIL div_neg_quo: got %h expected fffffffd", bus.lo); end
    tests++; if (bus.hi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL div_neg_rem: got %h expected ffffffff", bus.hi); end
    @(negedge clk);
    run_op(2'b11, 32'd100, 32'd7, lat, bc, ov, mv);
    tests++; if (bus.lo !== 32'd14) begin fails++; $display("FAIL divu_quo: got %h expected 0000000e", bus.lo); end
    tests++; if (bus.hi !== 32'd2) begin fails++; $display("FAIL divu_rem: got %h expected 00000002", bus.hi); end
    @(negedge clk);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc, ov, mv);
    tests++; if (bus.lo !== 32'h8000_0000) begin fails++; $display("FAIL div_ovf_quo: got %h expected 80000000", bus.lo); end
    tests++; if (bus.hi !== 32'h0) begin fails++; $display("FAIL div_ovf_rem: got %h expected 0", bus.hi); end
    tests++; if (bus.div_zero !== 1'b0) begin fails++; $display("FAIL div_ovf_dz: got %b expected 0", bus.div_zero); end
    @(negedge clk);
  endtask

  task automatic test_div_zero();
    int lat, bc; bit ov, mv;
    bus.a = 32'h11; bus.hi_we = 1'b1;
    @(negedge clk);
    bus.hi_we = 1'b0; bus.a = 32'h22; bus.lo_we = 1'b1;
    @(negedge clk);
    bus.lo_we = 1'b0;
    tests++; if (bus.hi !== 32'h11) begin fails++; $display("FAIL mthi: got %h expected 00000011", bus.hi); end
    tests++; if (bus.lo !== 32'h22) begin fails++; $display("FAIL mtlo: got %h expected 00000022", bus.lo); end
    run_op(2'b11, 32'd100, 32'd0, lat, bc, ov, mv);
    tests++; if (lat !== 2) begin fails++; $display("FAIL dz_latency: got %0d expected 2", lat); end
    tests++; if (bus.div_zero !== 1'b1) begin fails++; $display("FAIL dz_flag: got %b expected 1", bus.div_zero); end
    tests++; if (bus.hi !== 32'h11) begin fails++; $display("FAIL dz_hi_hold: got %h expected 00000011", bus.hi); end
    tests++; if (bus.lo !== 32'h22) begin fails++; $display("FAIL dz_lo_hold: got %h expected 00000022", bus.lo); end
    repeat (3) @(negedge clk);
    tests++; if (bus.div_zero !== 1'b1) begin fails++; $display("FAIL dz_sticky: got %b expected 1", bus.div_zero); end
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd3; bus.b = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    tests++; if (bus.div_zero !== 1'b0) begin fails++; $display("FAIL dz_clear: got %b expected 0", bus.div_zero); end
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL dz_next_busy: got %b expected 1", bus.busy); end
    lat = 1;
    while (!bus.done && lat < LIMIT) begin @(negedge clk); lat++; end
    tests++; if (bus.lo !== 32'd12) begin fails++; $display("FAIL dz_next_lo: got %h expected 0000000c", bus.lo); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat, bc; bit ov, mv;
    run_op(2'b11, 32'd100, 32'd7, lat, bc, ov, mv);
    tests++; if (bus.lo !== 32'd14 || bus.hi !== 32'd2) begin fails++; $display("FAIL b2b_first: got hi=%h lo=%h expected hi=00000002 lo=0000000e", bus.hi, bus.lo); end
    run_op(2'b01, 32'd7, 32'd9, lat, bc, ov, mv);
    tests++; if (lat !== 34) begin fails++; $display("FAIL b2b_latency: got %0d expected 34", lat); end
    tests++; if (bus.hi !== 32'h0 || bus.lo !== 32'd63) begin fails++; $display("FAIL b2b_second: got hi=%h lo=%h expected hi=0 lo=0000003f", bus.hi, bus.lo); end
    @(negedge clk);
  endtask

  task automatic test_busy_ignore();
    int lat;
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd5; bus.b = 32'd6;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (lat < 10) begin @(negedge clk); lat++; end
    bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'h1234; bus.b = 32'd1;
    bus.hi_we = 1'b1; bus.lo_we = 1'b1;
    @(negedge clk);
    lat++;
    bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    while (!bus.done && lat < LIMIT) begin @(negedge clk); lat++; end
    tests++; if (lat !== 34) begin fails++; $display("FAIL ignore_latency: got %0d expected 34", lat); end
    tests++; if (bus.hi !== 32'h0) begin fails++; $display("FAIL ignore_hi: got %h expected 0", bus.hi); end
    tests++; if (bus.lo !== 32'd30) begin fails++; $display("FAIL ignore_lo: got %h expected 0000001e", bus.lo); end
    @(negedge clk);
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL ignore_not_queued: got %b expected 0", bus.busy); end
  endtask

  task automatic test_reset_midop();
    int cyc;
    bit seen_done;
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd5; bus.b = 32'd6;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL midrst_done: got %b expected 0", bus.done); end
    tests++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin fails++; $display("FAIL midrst_hilo: got hi=%h lo=%h expected 0", bus.hi, bus.lo); end
    @(negedge clk);
    reset = 1'b0;
    seen_done = 1'b0;
    for (cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen_done = 1'b1;
    end
    tests++; if (seen_done !== 1'b0) begin fails++; $display("FAIL midrst_no_done: got %b expected 0", seen_done); end
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    reset = 1'b0;
    @(negedge clk);
    test_multu();
    test_mult();
    test_div();
    test_div_zero();
    test_back_to_back();
    test_busy_ignore();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Parametrised multicycle multiply/divide unit with HI/LO result registers, serving MULT, MULTU, DIV, DIVU, MFHI/MFLO, MTHI and MTLO in the multicycle datapath. The control unit pulses start with operands from A and B, then waits on busy/done. Results are read from hi/lo into the register-bank write-data mux. The unit computes one bit per cycle with a shift-add multiplier and a restoring divider, both width-generic.

Parameters:
WIDTH, 32, operand and HI/LO width (>= 4)

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-high
start  input  1  request; accepted only in IDLE
op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
a  input  WIDTH  multiplicand / dividend (rs)
b  input  WIDTH  multiplier / divisor (rt)
hi_we  input  1  MTHI: load a into hi (IDLE only)
lo_we  input  1  MTLO: load a into lo (IDLE only)
busy  output  1  operation in progress
done  output  1  one-cycle completion pulse
div_zero  output  1  last accepted DIV/DIVU had b == 0
hi  output  WIDTH  MULT: upper product half; DIV: remainder
lo  output  WIDTH  MULT: lower product half; DIV: quotient

Behaviour:
- Reset (async, any state): state IDLE; hi, lo, busy, done, div_zero = 0; iteration counter = 0.
- States: IDLE, RUN, FIX.
- IDLE:
  - When start = 1, the unit latches op, |a| and |b| (magnitudes for signed ops; raw values for unsigned ops), and the result-sign bits.
  - Same edge: clears div_zero; moves to RUN; busy = 1 from the next cycle.
  - Later changes on a and b have no effect on the operation in flight.
- Divide by zero (op DIV/DIVU with b == 0 at start): no RUN. The unit goes directly to FIX.
  - FIX sets div_zero = 1, leaves hi/lo unchanged and pulses done.
  - done is high in cycle 2 after the start edge.
- RUN: exactly WIDTH cycles, counter 0..WIDTH-1, then FIX.
  - Multiply: 2*WIDTH-bit accumulator. Each cycle adds the multiplicand if the current multiplier LSB is set, then shifts.
  - Divide: restoring algorithm. Each cycle shifts the remainder/quotient pair left, trial-subtracts the divisor, and keeps the result if it is non-negative, setting the quotient bit.
- FIX (one cycle): applies sign correction and writes hi/lo. Returns to IDLE with done = 1 and busy = 0 for that cycle.
  - MULT: product is negated (2*WIDTH-bit two's complement) when the signs of a and b differ.
  - DIV: quotient is negated when the signs differ; remainder takes the sign of the dividend.
  - Signed overflow (MIN / -1): lo = MIN, hi = 0 (natural wrap, no flag).
- Latency: with start sampled at edge E0, done and the new hi/lo are visible after edge E(WIDTH+1). That is 34 cycles for WIDTH = 32.
- hi/lo update only in FIX, or via hi_we/lo_we in IDLE. They otherwise hold their value, including during RUN.
- hi_we/lo_we:
  - Honoured only in IDLE with start = 0. The register loads a on that edge.
  - hi_we and lo_we together load both registers.
  - Ignored while busy, and ignored when start = 1 in the same cycle (start wins).
- start while busy: ignored, not queued.
- done never overlaps busy. Back-to-back operation is allowed: a start in the done cycle (state IDLE) is accepted.
- div_zero holds until the next accepted start.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → done 34 cycles after start; hi=0xFFFFFFFE, lo=0x00000001; busy high for the 33 cycles before done.
- MULT a=0xFFFFFFFD (-3), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then MULT a=0x80000000, b=0x80000000 → hi=0x40000000, lo=0.
- DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 → lo=14, hi=2.
- DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0, div_zero=0.
- Preload hi=0x11, lo=0x22 via hi_we/lo_we, then DIVU a=100, b=0 → done in 2nd cycle after start, div_zero=1, hi=0x11, lo=0x22. The next MULTU start clears div_zero.
- Start MULTU 5×6, and at cycle 10 pulse start (op DIV), hi_we and lo_we → all ignored; result hi=0, lo=30. Then start again and assert reset at cycle 5 → immediately busy=0, done=0, hi=lo=0, and no done pulse follows.
